// File: rtl/frame_update_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// frame_update_ctrl_pkg
// Shared clocking constants and FSM state encoding for the frame update
// controller.
//   INPUT_CLOCK_SPEED       system clock frequency in Hz (clk_50)
//   REFRESH_RATE            display refresh rate in Hz
//   DEFAULT_TIMEOUT_CYCLES  clk_50 cycles in one refresh period
//   state_t                 IDLE -> PENDING -> RUN -> IDLE
// -----------------------------------------------------------------------------
package frame_update_ctrl_pkg;

    localparam int INPUT_CLOCK_SPEED      = 50_000_000;
    localparam int REFRESH_RATE           = 60;
    localparam int DEFAULT_TIMEOUT_CYCLES = INPUT_CLOCK_SPEED / REFRESH_RATE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

endpackage

// File: rtl/frame_update_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// frame_update_ctrl_sat_counter
// Saturating up-counter with synchronous clear. When clr and inc arrive in
// the same cycle, the clear is applied first and the increment lands on top,
// so the result is 1.
//   clk_50  in   1      system clock
//   reset   in   1      asynchronous, active-high reset
//   inc     in   1      count one event (ignored at all-ones)
//   clr     in   1      synchronous clear
//   count   out  WIDTH  current count
// -----------------------------------------------------------------------------
module frame_update_ctrl_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? WIDTH'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/frame_update_ctrl.sv
// -----------------------------------------------------------------------------
// frame_update_ctrl
// Turns the one-cycle refresh tick into a frame-update handshake with the game
// logic, aligned to vertical blanking, and keeps debug counters.
//   clk_50        in   1            50 MHz system clock
//   reset         in   1            asynchronous, active-high reset
//   refresh_tick  in   1            one-cycle refresh pulse
//   vblank        in   1            high during vertical blank
//   update_done   in   1            one-cycle pulse: game update finished
//   clear_status  in   1            one-cycle pulse: clear missed_ticks/timeout_err
//   update_start  out  1            one-cycle pulse on the first RUN cycle
//   update_busy   out  1            high while PENDING or RUN
//   frame_count   out  FRAME_CNT_W  completed updates (wraps)
//   missed_ticks  out  MISS_CNT_W   ticks dropped while busy (saturates)
//   timeout_err   out  1            sticky: an update ran too long
// -----------------------------------------------------------------------------
module frame_update_ctrl
    import frame_update_ctrl_pkg::*;
#(
    parameter int FRAME_CNT_W    = 16,
    parameter int MISS_CNT_W     = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   clk_50,
    input  logic                   reset,
    input  logic                   refresh_tick,
    input  logic                   vblank,
    input  logic                   update_done,
    input  logic                   clear_status,
    output logic                   update_start,
    output logic                   update_busy,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [MISS_CNT_W-1:0]  missed_ticks,
    output logic                   timeout_err
);

    localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [TCNT_W-1:0] tcnt;
    logic              in_run;
    logic              miss_inc;

    assign in_run      = (state == ST_RUN);
    assign update_busy = (state == ST_PENDING) || in_run;

    // A tick in RUN is only accepted when it coincides with update_done; it
    // then becomes the next PENDING request instead of a miss. At timeout
    // expiry done is low, so the tick is counted.
    assign miss_inc = refresh_tick && ((state == ST_PENDING) || (in_run && !update_done));

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            update_start <= 1'b0;
            frame_count  <= '0;
            timeout_err  <= 1'b0;
            tcnt         <= '0;
        end else begin
            // NOTE: the default-low pulse and the clear are written first; a
            // later assignment in this block to the same register wins, which
            // is how the start pulse and a same-cycle timeout override them.
            update_start <= 1'b0;
            if (clear_status) begin
                timeout_err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (refresh_tick) begin
                        state <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (vblank) begin
                        state        <= ST_RUN;
                        update_start <= 1'b1;
                        tcnt         <= '0;
                    end
                end
                ST_RUN: begin
                    if (update_done) begin
                        frame_count <= frame_count + FRAME_CNT_W'(1);
                        state       <= refresh_tick ? ST_PENDING : ST_IDLE;
                    end else if (tcnt == TCNT_LAST) begin
                        state       <= ST_IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    frame_update_ctrl_sat_counter #(
        .WIDTH (MISS_CNT_W)
    ) u_missed_cnt (
        .clk_50 (clk_50),
        .reset  (reset),
        .inc    (miss_inc),
        .clr    (clear_status),
        .count  (missed_ticks)
    );

endmodule

// File: tb/tb_frame_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_update_ctrl
// Scoreboard bench: the stimulus pushes the expected update_start cycle and
// expected frame_count values; a negedge monitor pops and compares them as the
// DUT produces them. Point checks cover busy, counters and sticky flags.
// frame_count is narrowed to 8 bits so the all-ones wrap is reached quickly;
// the timeout is shortened to 16 cycles.
// -----------------------------------------------------------------------------
module tb_frame_update_ctrl;

    localparam int FCW = 8;
    localparam int MCW = 8;
    localparam int TOC = 16;

    logic           clk_50 = 1'b0;
    logic           reset;
    logic           refresh_tick;
    logic           vblank;
    logic           update_done;
    logic           clear_status;
    logic           update_start;
    logic           update_busy;
    logic [FCW-1:0] frame_count;
    logic [MCW-1:0] missed_ticks;
    logic           timeout_err;

    int             n_checks = 0;
    int             n_errors = 0;
    int             cyc = 0;
    int             sb_start[$];
    int             sb_frame[$];
    logic [FCW-1:0] exp_fc = '0;
    logic [FCW-1:0] prev_fc = '0;
    int             c0;

    frame_update_ctrl #(
        .FRAME_CNT_W    (FCW),
        .MISS_CNT_W     (MCW),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk_50       (clk_50),
        .reset        (reset),
        .refresh_tick (refresh_tick),
        .vblank       (vblank),
        .update_done  (update_done),
        .clear_status (clear_status),
        .update_start (update_start),
        .update_busy  (update_busy),
        .frame_count  (frame_count),
        .missed_ticks (missed_ticks),
        .timeout_err  (timeout_err)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    task automatic expect_frame();
        exp_fc = exp_fc + FCW'(1);
        sb_frame.push_back(int'(exp_fc));
    endtask

    // Monitor: every update_start and every frame_count change must match the
    // head of its scoreboard queue; an empty queue yields an impossible value.
    always @(negedge clk_50) begin
        int e;
        if (reset) begin
            prev_fc = '0;
        end else begin
            if (update_start) begin
                e = (sb_start.size() != 0) ? sb_start.pop_front() : -1;
                check("start_cycle", 32'(cyc), 32'(e));
            end
            if (frame_count != prev_fc) begin
                e = (sb_frame.size() != 0) ? sb_frame.pop_front() : -1;
                check("frame_count", 32'(frame_count), 32'(e));
                prev_fc = frame_count;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, 32'(update_start), 0);
        check({tag, "_busy"},  32'(update_busy), 0);
        check({tag, "_fc"},    32'(frame_count), 0);
        check({tag, "_miss"},  32'(missed_ticks), 0);
        check({tag, "_terr"},  32'(timeout_err), 0);
    endtask

    initial begin
        reset        = 1'b1;
        refresh_tick = 1'b0;
        vblank       = 1'b1;
        update_done  = 1'b0;
        clear_status = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // 1: tick with vblank high, start two cycles later, done at c10
        c0 = cyc;
        refresh_tick = 1'b1;
        sb_start.push_back(c0 + 2);
        step();
        refresh_tick = 1'b0;
        check("t1_busy_c1", 32'(update_busy), 1);
        repeat (9) step();
        check("t1_busy_c10", 32'(update_busy), 1);
        update_done = 1'b1;
        expect_frame();
        step();
        update_done = 1'b0;
        check("t1_busy_c11", 32'(update_busy), 0);
        check("t1_fc_c11", 32'(frame_count), 1);

        // 2: vblank low, rises at c50 -> start at c51 only
        vblank = 1'b0;
        c0 = cyc;
        refresh_tick = 1'b1;
        sb_start.push_back(c0 + 51);
        step();
        refresh_tick = 1'b0;
        repeat (49) step();
        check("t2_busy_c50", 32'(update_busy), 1);
        vblank = 1'b1;
        step();
        update_done = 1'b1;
        expect_frame();
        step();
        update_done = 1'b0;
        check("t2_busy_end", 32'(update_busy), 0);

        // 3: three ticks in RUN, then saturation while stuck in PENDING
        c0 = cyc;
        refresh_tick = 1'b1;
        sb_start.push_back(c0 + 2);
        step();
        refresh_tick = 1'b0;
        step();
        refresh_tick = 1'b1;
        repeat (3) step();
        refresh_tick = 1'b0;
        check("t3_miss3", 32'(missed_ticks), 3);
        update_done = 1'b1;
        expect_frame();
        step();
        update_done = 1'b0;
        vblank = 1'b0;
        refresh_tick = 1'b1;
        repeat (301) step();
        refresh_tick = 1'b0;
        check("t3_miss_sat", 32'(missed_ticks), 255);
        check("t3_busy_pend", 32'(update_busy), 1);
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        check("t3_miss_clr", 32'(missed_ticks), 0);
        clear_status = 1'b1;
        refresh_tick = 1'b1;
        step();
        clear_status = 1'b0;
        refresh_tick = 1'b0;
        check("t3_clr_and_miss", 32'(missed_ticks), 1);
        vblank = 1'b1;
        sb_start.push_back(cyc + 1);
        step();
        update_done = 1'b1;
        expect_frame();
        step();
        update_done = 1'b0;
        check("t3_busy_end", 32'(update_busy), 0);

        // 4a: no done -> timeout after 16 RUN cycles
        c0 = cyc;
        refresh_tick = 1'b1;
        sb_start.push_back(c0 + 2);
        step();
        refresh_tick = 1'b0;
        repeat (16) step();
        check("t4_busy_c17", 32'(update_busy), 1);
        check("t4_terr_c17", 32'(timeout_err), 0);
        step();
        check("t4_busy_c18", 32'(update_busy), 0);
        check("t4_terr_c18", 32'(timeout_err), 1);
        check("t4_fc_same", 32'(frame_count), 32'(exp_fc));
        c0 = cyc;
        refresh_tick = 1'b1;
        sb_start.push_back(c0 + 2);
        step();
        refresh_tick = 1'b0;
        step();
        update_done = 1'b1;
        expect_frame();
        step();
        update_done = 1'b0;
        check("t4_terr_sticky", 32'(timeout_err), 1);

        // 4b: tick and clear at expiry -> timeout wins, tick missed after clear
        c0 = cyc;
        refresh_tick = 1'b1;
        sb_start.push_back(c0 + 2);
        step();
        refresh_tick = 1'b0;
        repeat (16) step();
        clear_status = 1'b1;
        refresh_tick = 1'b1;
        step();
        clear_status = 1'b0;
        refresh_tick = 1'b0;
        check("t4b_busy", 32'(update_busy), 0);
        check("t4b_terr", 32'(timeout_err), 1);
        check("t4b_miss", 32'(missed_ticks), 1);

        // 4c: done at the expiry cycle wins over timeout
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        check("t4c_clr_terr", 32'(timeout_err), 0);
        c0 = cyc;
        refresh_tick = 1'b1;
        sb_start.push_back(c0 + 2);
        step();
        refresh_tick = 1'b0;
        repeat (16) step();
        update_done = 1'b1;
        expect_frame();
        step();
        update_done = 1'b0;
        check("t4c_terr", 32'(timeout_err), 0);
        check("t4c_busy", 32'(update_busy), 0);

        // 5: tick and done together -> straight back to PENDING, no miss
        c0 = cyc;
        refresh_tick = 1'b1;
        sb_start.push_back(c0 + 2);
        step();
        refresh_tick = 1'b0;
        step();
        update_done = 1'b1;
        refresh_tick = 1'b1;
        expect_frame();
        sb_start.push_back(c0 + 4);
        step();
        update_done = 1'b0;
        refresh_tick = 1'b0;
        check("t5_busy_pend", 32'(update_busy), 1);
        check("t5_miss", 32'(missed_ticks), 0);
        step();
        update_done = 1'b1;
        expect_frame();
        step();
        update_done = 1'b0;
        check("t5_busy_end", 32'(update_busy), 0);

        // 6: asynchronous reset mid-RUN, later done ignored
        c0 = cyc;
        refresh_tick = 1'b1;
        sb_start.push_back(c0 + 2);
        step();
        refresh_tick = 1'b0;
        repeat (2) step();
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("t6_async");
        step();
        step();
        reset = 1'b0;
        exp_fc = '0;
        update_done = 1'b1;
        step();
        update_done = 1'b0;
        step();
        check("t6_done_ign_fc", 32'(frame_count), 0);
        check("t6_done_ign_busy", 32'(update_busy), 0);

        // 6b: frame_count wraps from all-ones back to zero
        for (int i = 0; i < (1 << FCW); i++) begin
            c0 = cyc;
            refresh_tick = 1'b1;
            sb_start.push_back(c0 + 2);
            step();
            refresh_tick = 1'b0;
            step();
            update_done = 1'b1;
            expect_frame();
            step();
            update_done = 1'b0;
        end
        step();
        check("t6_wrap_fc", 32'(frame_count), 0);

        check("sb_start_drained", 32'(sb_start.size()), 0);
        check("sb_frame_drained", 32'(sb_frame.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
